// File: rtl/uart_cmd_pkg.sv
// Opcode, reply and FSM state definitions shared by the UART command engine.
// Pure declarations: no logic, no latency, no flow control.
package uart_cmd_pkg;
   localparam logic [7:0] OP_ACQ  = 8'h41;
   localparam logic [7:0] OP_FREE = 8'h46;
   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;

   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_NOOWN = 8'h4E;
   localparam logic [7:0] RSP_BADOP = 8'h3F;
   localparam logic [7:0] RSP_TMO   = 8'h21;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARGS,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } cmd_state_t;
endpackage

// File: rtl/uart_cmd_resp_tx.sv
// Two-byte reply buffer: load presents byte0 on the next cycle, byte1 follows its handshake.
// tx_valid/tx_data hold until tx_ready; done pulses combinationally on the final handshake.
module uart_cmd_resp_tx (
   input  logic       u_clk,
   input  logic       u_rst_n,
   input  logic       load,
   input  logic [1:0] load_cnt,
   input  logic [7:0] load_b0,
   input  logic [7:0] load_b1,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       done
);
   logic [7:0] b1_q;
   logic       b1_pend;

   always_ff @(posedge u_clk or negedge u_rst_n) begin
      if (!u_rst_n) begin
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         b1_q     <= 8'h00;
         b1_pend  <= 1'b0;
      end else if (load) begin
         tx_data  <= load_b0;
         tx_valid <= 1'b1;
         b1_q     <= load_b1;
         b1_pend  <= (load_cnt == 2'd2);
      end else if (tx_valid && tx_ready) begin
         if (b1_pend) begin
            tx_data <= b1_q;
            b1_pend <= 1'b0;
         end else begin
            tx_valid <= 1'b0;
         end
      end
   end

   assign done = tx_valid && tx_ready && !b1_pend;
endmodule

// File: rtl/sram_uart_cmd_engine.sv
// Host byte-protocol parser driving the SRAM bridge request side and returning 1-2 reply bytes.
// Request pulse one cycle after the last argument (stalls while u_busy); reply one cycle after u_done, held until tx_ready.
module sram_uart_cmd_engine
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        u_clk,
   input  logic        u_rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        u_req,
   output logic        u_wr_req,
   output logic        u_rd_req,
   output logic [15:0] u_addr,
   output logic [15:0] u_wdata,
   input  logic [15:0] u_rdata,
   input  logic        u_done,
   input  logic        u_busy,
   output logic        rx_overrun
);
   cmd_state_t  state, state_n;
   logic [23:0] arg_buf;
   logic [31:0] arg_nxt;
   logic [2:0]  arg_left;
   logic        is_wr;
   logic [31:0] tmo_cnt;
   logic        last_arg, tmo_hit;

   logic        resp_load, resp_done;
   logic [1:0]  resp_cnt;
   logic [7:0]  resp_b0, resp_b1;
   logic        req_set, req_clr, addr_load;

   assign arg_nxt  = {arg_buf, rx_data};
   assign last_arg = rx_valid && (arg_left == 3'd1);
   // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && !rx_valid &&
                     (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge u_clk or negedge u_rst_n) begin
      if (!u_rst_n) state <= ST_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n   = state;
      resp_load = 1'b0;
      resp_cnt  = 2'd1;
      resp_b0   = RSP_OK;
      resp_b1   = 8'h00;
      req_set   = 1'b0;
      req_clr   = 1'b0;
      addr_load = 1'b0;
      u_wr_req  = 1'b0;
      u_rd_req  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (rx_valid) begin
               state_n   = ST_RESP;
               resp_load = 1'b1;
               case (rx_data)
                  OP_ACQ:  req_set = 1'b1;
                  OP_FREE: req_clr = 1'b1;
                  OP_WR, OP_RD: begin
                     resp_load = 1'b0;
                     state_n   = ST_ARGS;
                  end
                  default: resp_b0 = RSP_BADOP;
               endcase
            end
         end
         ST_ARGS: begin
            if (last_arg) begin
               if (u_req) begin
                  addr_load = 1'b1;
                  state_n   = ST_ISSUE;
               end else begin
                  resp_load = 1'b1;
                  resp_b0   = RSP_NOOWN;
                  state_n   = ST_RESP;
               end
            end else if (tmo_hit) begin
               resp_load = 1'b1;
               resp_b0   = RSP_TMO;
               state_n   = ST_RESP;
            end
         end
         ST_ISSUE: begin
            if (!u_busy) begin
               u_wr_req = is_wr;
               u_rd_req = !is_wr;
               state_n  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (u_done) begin
               resp_load = 1'b1;
               state_n   = ST_RESP;
               if (!is_wr) begin
                  resp_cnt = 2'd2;
                  resp_b0  = u_rdata[15:8];
                  resp_b1  = u_rdata[7:0];
               end
            end
         end
         ST_RESP: begin
            if (resp_done) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge u_clk or negedge u_rst_n) begin
      if (!u_rst_n) begin
         u_req      <= 1'b0;
         arg_buf    <= 24'h0;
         arg_left   <= 3'd0;
         is_wr      <= 1'b0;
         tmo_cnt    <= 32'd0;
         u_addr     <= 16'h0;
         u_wdata    <= 16'h0;
         rx_overrun <= 1'b0;
      end else begin
         if (req_set)      u_req <= 1'b1;
         else if (req_clr) u_req <= 1'b0;

         if (state == ST_IDLE && rx_valid) begin
            is_wr    <= (rx_data == OP_WR);
            arg_left <= (rx_data == OP_WR) ? 3'd4 : 3'd2;
            arg_buf  <= 24'h0;
         end else if (state == ST_ARGS && rx_valid) begin
            arg_buf  <= arg_nxt[23:0];
            arg_left <= arg_left - 3'd1;
         end

         tmo_cnt <= (state == ST_ARGS && !rx_valid) ? tmo_cnt + 32'd1 : 32'd0;

         // Bus-facing address/data only move once a command is committed to issue.
         if (addr_load) begin
            if (is_wr) begin
               u_addr  <= arg_nxt[31:16];
               u_wdata <= arg_nxt[15:0];
            end else begin
               u_addr  <= arg_nxt[15:0];
            end
         end

         if (rx_valid && (state == ST_ISSUE || state == ST_WAIT || state == ST_RESP))
            rx_overrun <= 1'b1;
      end
   end

   uart_cmd_resp_tx u_resp_tx (
      .u_clk    (u_clk),
      .u_rst_n  (u_rst_n),
      .load     (resp_load),
      .load_cnt (resp_cnt),
      .load_b0  (resp_b0),
      .load_b1  (resp_b1),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .done     (resp_done)
   );
endmodule
